// File: rtl/risc_pkg.sv
// rtl/risc_pkg.sv - opcodes, sequencer states and instruction field indices for the 8-bit RISC core
package risc_pkg;

    localparam logic [4:0] OP_ADD   = 5'b00000;
    localparam logic [4:0] OP_SUB   = 5'b00001;
    localparam logic [4:0] OP_AND   = 5'b00010;
    localparam logic [4:0] OP_OR    = 5'b00011;
    localparam logic [4:0] OP_XOR   = 5'b00100;
    localparam logic [4:0] OP_STORE = 5'b01000;
    localparam logic [4:0] OP_PUSH  = 5'b01001;
    localparam logic [4:0] OP_POP   = 5'b01010;
    localparam logic [4:0] OP_JMP   = 5'b01100;
    localparam logic [4:0] OP_JZ    = 5'b01101;
    localparam logic [4:0] OP_JC    = 5'b01110;
    localparam logic [4:0] OP_HALT  = 5'b11111;

    localparam int IMM_BIT = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_F0,
        S_F1,
        S_DEC,
        S_EX,
        S_EXM,
        S_HALT
    } state_t;

endpackage

// File: rtl/risc_decode.sv
// rtl/risc_decode.sv - instruction class flags from the opcode/mode fields of IR0
module risc_decode
    import risc_pkg::*;
(
    input  logic [4:0] i_op,
    input  logic       i_imm,
    output logic       o_is_alu,
    output logic       o_is_mem,
    output logic       o_is_jump,
    output logic       o_sets_carry
);

    always_comb begin
        o_is_alu     = i_op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR};
        o_is_mem     = o_is_alu && !i_imm;
        o_is_jump    = i_op inside {OP_JMP, OP_JZ, OP_JC};
        o_sets_carry = i_op inside {OP_ADD, OP_SUB};
    end

endmodule

// File: rtl/risc_seq_ctrl.sv
// rtl/risc_seq_ctrl.sv - fetch/decode/execute sequencer owning PC and IR
// Strobes are decoded from registered state and IR, so async reset clears them at once.
module risc_seq_ctrl
    import risc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic [7:0] i_start_addr,
    input  logic [7:0] i_sram_data,
    input  logic       i_zflag,
    input  logic       i_cflag,
    output logic [7:0] o_sram_addr,
    output logic       o_sram_read,
    output logic       o_sram_write,
    output logic       o_stack_read,
    output logic       o_stack_write,
    output logic [4:0] o_alu_opcode,
    output logic       o_imm7,
    output logic       o_alu_save,
    output logic       o_zflag_save,
    output logic       o_cflag_save,
    output logic [7:0] o_operand2,
    output logic       o_halted
);

    state_t     r_state;
    logic [7:0] r_pc;
    logic [4:0] r_ir0_op;
    logic       r_ir0_imm;
    logic [7:0] r_ir1;

    logic w_is_alu;
    logic w_is_mem;
    logic w_is_jump;
    logic w_sets_carry;
    logic w_take_jump;

    risc_decode u_decode (
        .i_op         (r_ir0_op),
        .i_imm        (r_ir0_imm),
        .o_is_alu     (w_is_alu),
        .o_is_mem     (w_is_mem),
        .o_is_jump    (w_is_jump),
        .o_sets_carry (w_sets_carry)
    );

    assign w_take_jump = (r_ir0_op == OP_JMP)
                       || ((r_ir0_op == OP_JZ) && i_zflag)
                       || ((r_ir0_op == OP_JC) && i_cflag);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_pc      <= 8'h00;
            r_ir0_op  <= 5'd0;
            r_ir0_imm <= 1'b0;
            r_ir1     <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_pc    <= i_start_addr;
                        r_state <= S_F0;
                    end
                end
                S_F0:  r_state <= S_F1;
                S_F1: begin
                    r_ir0_op  <= i_sram_data[7:3];
                    r_ir0_imm <= i_sram_data[IMM_BIT];
                    r_state   <= S_DEC;
                end
                S_DEC: begin
                    r_ir1   <= i_sram_data;
                    r_pc    <= r_pc + 8'd2;
                    r_state <= S_EX;
                end
                S_EX: begin
                    if (r_ir0_op == OP_HALT) begin
                        r_state <= S_HALT;
                    end else if (w_is_mem) begin
                        r_state <= S_EXM;
                    end else begin
                        if (w_is_jump && w_take_jump)
                            r_pc <= r_ir1;
                        r_state <= S_F0;
                    end
                end
                S_EXM:  r_state <= S_F0;
                S_HALT: r_state <= S_HALT;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        o_sram_addr   = 8'h00;
        o_sram_read   = 1'b0;
        o_sram_write  = 1'b0;
        o_stack_read  = 1'b0;
        o_stack_write = 1'b0;
        o_alu_save    = 1'b0;
        o_zflag_save  = 1'b0;
        o_cflag_save  = 1'b0;
        o_operand2    = 8'h00;
        case (r_state)
            S_F0: begin
                o_sram_read = 1'b1;
                o_sram_addr = r_pc;
            end
            S_F1: begin
                o_sram_read = 1'b1;
                o_sram_addr = r_pc + 8'd1;
            end
            S_EX: begin
                if (w_is_alu) begin
                    if (r_ir0_imm) begin
                        o_alu_save   = 1'b1;
                        o_zflag_save = 1'b1;
                        o_cflag_save = w_sets_carry;
                        o_operand2   = r_ir1;
                    end else begin
                        o_sram_read = 1'b1;
                        o_sram_addr = r_ir1;
                    end
                end
                case (r_ir0_op)
                    OP_STORE: begin
                        o_sram_write = 1'b1;
                        o_sram_addr  = r_ir1;
                    end
                    OP_PUSH: o_stack_write = 1'b1;
                    OP_POP:  o_stack_read  = 1'b1;
                    default: ;
                endcase
            end
            S_EXM: begin
                o_alu_save   = 1'b1;
                o_zflag_save = 1'b1;
                o_cflag_save = w_sets_carry;
                o_operand2   = i_sram_data;
            end
            default: ;
        endcase
    end

    assign o_alu_opcode = r_ir0_op;
    assign o_imm7       = r_ir0_imm;
    assign o_halted     = (r_state == S_HALT);

endmodule

// File: tb/tb_risc_seq_ctrl.sv
// tb/tb_risc_seq_ctrl.sv - directed and random instruction-level bench for risc_seq_ctrl
module tb_risc_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_start = 1'b0;
    logic [7:0] i_start_addr = 8'h00;
    logic [7:0] i_sram_data = 8'h00;
    logic       i_zflag = 1'b0;
    logic       i_cflag = 1'b0;
    logic [7:0] o_sram_addr;
    logic       o_sram_read;
    logic       o_sram_write;
    logic       o_stack_read;
    logic       o_stack_write;
    logic [4:0] o_alu_opcode;
    logic       o_imm7;
    logic       o_alu_save;
    logic       o_zflag_save;
    logic       o_cflag_save;
    logic [7:0] o_operand2;
    logic       o_halted;

    risc_seq_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_start       (i_start),
        .i_start_addr  (i_start_addr),
        .i_sram_data   (i_sram_data),
        .i_zflag       (i_zflag),
        .i_cflag       (i_cflag),
        .o_sram_addr   (o_sram_addr),
        .o_sram_read   (o_sram_read),
        .o_sram_write  (o_sram_write),
        .o_stack_read  (o_stack_read),
        .o_stack_write (o_stack_write),
        .o_alu_opcode  (o_alu_opcode),
        .o_imm7        (o_imm7),
        .o_alu_save    (o_alu_save),
        .o_zflag_save  (o_zflag_save),
        .o_cflag_save  (o_cflag_save),
        .o_operand2    (o_operand2),
        .o_halted      (o_halted)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    logic [7:0] pc;
    logic       rd_pend;
    logic [7:0] rd_addr;
    int         n_assert = 0;
    int         n_fail = 0;
    int         ops [13] = '{0, 1, 2, 3, 4, 8, 9, 10, 12, 13, 14, 5, 22};

    function automatic logic [23:0] ev(input logic rd, input logic wr, input logic srd, input logic swr,
                                       input logic asv, input logic zsv, input logic csv, input logic hlt,
                                       input logic [7:0] a, input logic [7:0] o2);
        return {rd, wr, srd, swr, asv, zsv, csv, hlt, a, o2};
    endfunction

    task automatic chk(input string tag, input logic [23:0] exp);
        logic [23:0] obs;
        obs = {o_sram_read, o_sram_write, o_stack_read, o_stack_write, o_alu_save, o_zflag_save,
               o_cflag_save, o_halted, (o_sram_read | o_sram_write) ? o_sram_addr : 8'h00,
               o_alu_save ? o_operand2 : 8'h00};
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s pc=%h: observed %h expected %h", tag, pc, obs, exp);
        end
    endtask

    task automatic chk_raw_zero(input string tag);
        n_assert++;
        assert ({o_sram_addr, o_alu_opcode, o_imm7, o_operand2} === 22'd0) else begin
            n_fail++;
            $error("FAIL %s: observed addr=%h opc=%h imm=%b op2=%h expected all zero",
                   tag, o_sram_addr, o_alu_opcode, o_imm7, o_operand2);
        end
    endtask

    // Advance one cycle; the SRAM answers a read on the following cycle, otherwise bus holds junk.
    task automatic step();
        rd_pend = o_sram_read;
        rd_addr = o_sram_addr;
        @(posedge clk);
        #1;
        i_sram_data = rd_pend ? mem[rd_addr] : 8'($urandom);
        #1;
    endtask

    task automatic start_at(input logic [7:0] a);
        i_start      = 1'b1;
        i_start_addr = a;
        step();
        i_start      = 1'b0;
        i_start_addr = 8'($urandom);
        pc           = a;
    endtask

    // Instruction-level reference: expected strobes per cycle from the bytes at pc.
    task automatic run_instr(input bit abort, input logic zf, input logic cf);
        logic [7:0] b0, b1, npc;
        logic [4:0] op;
        logic       imm, alu;
        b0  = mem[pc];
        b1  = mem[8'(pc + 8'd1)];
        op  = b0[7:3];
        imm = b0[0];
        alu = (op <= 5'd4);
        npc = 8'(pc + 8'd2);
        i_zflag = zf;
        i_cflag = cf;
        i_start = 1'($urandom);
        chk("F0", ev(1, 0, 0, 0, 0, 0, 0, 0, pc, 8'h00));
        step();
        chk("F1", ev(1, 0, 0, 0, 0, 0, 0, 0, 8'(pc + 8'd1), 8'h00));
        step();
        chk("DEC", ev(0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00));
        step();
        n_assert++;
        assert ({o_alu_opcode, o_imm7} === {op, imm}) else begin
            n_fail++;
            $error("FAIL EX_OPC: observed %h/%b expected %h/%b", o_alu_opcode, o_imm7, op, imm);
        end
        if (alu && imm)
            chk("EX_ALUI", ev(0, 0, 0, 0, 1, 1, op <= 5'd1, 0, 8'h00, b1));
        else if (alu)
            chk("EX_ALUM", ev(1, 0, 0, 0, 0, 0, 0, 0, b1, 8'h00));
        else begin
            case (op)
                5'd8:  chk("EX_STORE", ev(0, 1, 0, 0, 0, 0, 0, 0, b1, 8'h00));
                5'd9:  chk("EX_PUSH", ev(0, 0, 0, 1, 0, 0, 0, 0, 8'h00, 8'h00));
                5'd10: chk("EX_POP", ev(0, 0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00));
                default: chk("EX_QUIET", ev(0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00));
            endcase
            if (op == 5'd12 || (op == 5'd13 && zf) || (op == 5'd14 && cf))
                npc = b1;
        end
        step();
        if (alu && !imm) begin
            if (abort) begin
                i_start = 1'b0;
                rst_n   = 1'b0;
                #1;
                chk("RST_EXM", ev(0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00));
                chk_raw_zero("RST_EXM_RAW");
                return;
            end
            chk("EXM", ev(0, 0, 0, 0, 1, 1, op <= 5'd1, 0, 8'h00, mem[b1]));
            step();
        end
        pc = npc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        pc = 8'h00;
        repeat (2) @(posedge clk);
        #2;
        chk("RESET", ev(0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00));
        chk_raw_zero("RESET_RAW");
        rst_n = 1'b1;
        step();
        chk("IDLE", ev(0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00));
        step();

        mem[8'h00] = 8'h01; mem[8'h01] = 8'h05;
        mem[8'h02] = 8'h10; mem[8'h03] = 8'h80; mem[8'h80] = 8'h3C;
        mem[8'h04] = 8'h68; mem[8'h05] = 8'h40;
        mem[8'h40] = 8'h68; mem[8'h41] = 8'h10;
        mem[8'h42] = 8'h12; mem[8'h43] = 8'h90;
        start_at(8'h00);
        run_instr(0, 1'b0, 1'b1);
        run_instr(0, 1'b0, 1'b0);
        run_instr(0, 1'b1, 1'b0);
        run_instr(0, 1'b0, 1'b1);
        run_instr(1, 1'b0, 1'b0);

        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("IDLE_AFTER_RST", ev(0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00));
            step();
        end

        mem[8'hFF] = 8'h28; mem[8'h00] = 8'h77;
        start_at(8'hFF);
        run_instr(0, 1'($urandom), 1'($urandom));

        for (int n = 0; n < 60; n++) begin
            mem[pc] = {5'(ops[$urandom_range(0, 12)]), 3'($urandom)};
            mem[8'(pc + 8'd1)] = 8'($urandom);
            run_instr(0, 1'($urandom), 1'($urandom));
        end

        mem[pc] = 8'h49; mem[8'(pc + 8'd1)] = 8'($urandom);
        run_instr(0, 1'($urandom), 1'($urandom));
        mem[pc] = 8'h50; mem[8'(pc + 8'd1)] = 8'($urandom);
        run_instr(0, 1'($urandom), 1'($urandom));
        mem[pc] = 8'h40; mem[8'(pc + 8'd1)] = 8'($urandom);
        run_instr(0, 1'($urandom), 1'($urandom));
        mem[pc] = 8'hF8; mem[8'(pc + 8'd1)] = 8'($urandom);
        run_instr(0, 1'($urandom), 1'($urandom));
        for (int i = 0; i < 6; i++) begin
            i_start = ~i_start;
            chk("HALTED", ev(0, 0, 0, 0, 0, 0, 0, 1, 8'h00, 8'h00));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/risc_seq_ctrl.md
# risc_seq_ctrl

Multicycle fetch/decode/execute sequencer for the 8-bit RISC datapath. It fetches two-byte instructions from the shared SRAM and decodes them. It then drives the ALU, SRAM and Stack strobes so that no two datapath resources conflict. It sits between the program SRAM and the ALU/Stack blocks and owns the program counter.

## Interface
- No parameters; widths are fixed at 8-bit data/address and 5-bit opcode.
- clk  in  1  clock; all state updates on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Start  in  1  level; sampled only in IDLE; begins execution at StartAddr
- StartAddr  in  8  initial PC
- SRAMData  in  8  SRAM Dataout; valid the cycle after SRAMRead was asserted
- Zflag, Cflag  in  1  ALU flags
- SRAMAddr  out  8  SRAM address (PC, PC+1 or operand byte)
- SRAMRead, SRAMWrite  out  1  SRAM strobes; never both high
- StackRead, StackWrite  out  1  pop/push strobes; never both high
- ALUOpcode  out  5  opcode to the ALU
- Imm7  out  1  ALU immediate select (instruction bit 0)
- ALUSave, ZflagSave, CflagSave  out  1  ALU capture strobes
- Operand2  out  8  ALU Operand2: the IR1 byte for immediate ops, SRAMData for memory ops
- Halted  out  1  high in HALT state

## Operation
- Instruction format: byte0 = {op[4:0], mode[2:0]}, byte1 = operand/address. Only mode[0] is used (1 = immediate).
- Opcodes:
  - 00000–00100: ADD/SUB/AND/OR/XOR, applied as ALUout <= ALUout op Operand2.
  - 01000: STORE, SRAM[IR1] <= ALUout (the data path is external).
  - 01001: PUSH. 01010: POP.
  - 01100: JMP. 01101: JZ. 01110: JC.
  - 11111: HALT. All other opcodes: NOP.
- States and transitions:
  - IDLE: on Start, PC <= StartAddr and go to F0.
  - F0: SRAMAddr=PC, SRAMRead=1.
  - F1: SRAMAddr=PC+1, SRAMRead=1; IR0 <= SRAMData.
  - DEC: IR1 <= SRAMData; PC <= PC+2.
  - EX: execute per opcode.
  - EXM: the second cycle of a memory-operand ALU op.
  - HALT: absorbing; only Reset_n leaves it.
- EX by opcode:
  - ALU op, immediate: ALUSave=1 and Operand2=IR1, then go to F0.
  - ALU op, memory: SRAMRead=1 with SRAMAddr=IR1, then go to EXM. In EXM: ALUSave=1 and Operand2=SRAMData, then go to F0.
  - STORE: SRAMWrite=1 with SRAMAddr=IR1. PUSH: StackWrite=1. POP: StackRead=1. Each is one cycle, then go to F0.
  - JMP: PC <= IR1. JZ/JC: PC <= IR1 only if Zflag/Cflag is sampled 1 in EX; otherwise PC is unchanged.
  - HALT: go to HALT.
- Flag strobes: ZflagSave accompanies every ALUSave. CflagSave accompanies ALUSave only for ADD and SUB.
- All strobes are single-cycle and decoded from registered state and IR. At most one resource strobe group is active per cycle.
- PC arithmetic is modulo 256: PC+1 and PC+2 wrap (0xFF+1=0x00; byte1 of an instruction at 0xFF is read from 0x00).

## Timing
- Reset (async, while Reset_n=0):
  - State=IDLE, PC=0, IR0=IR1=0.
  - Every output is 0, including SRAMAddr, ALUOpcode and Operand2.
  - Reset mid-instruction aborts the instruction immediately; no strobe survives the reset assertion.
- Instruction latency:
  - 4 cycles for immediate ALU ops, STORE, PUSH, POP, jumps and NOP.
  - 5 cycles for memory ALU ops.
- The first F0 occurs the cycle after Start is sampled in IDLE. Start is ignored outside IDLE.
- Flags are sampled in EX of the jump. An ALU op immediately preceding the jump has already updated the flags, because its ALUSave edge precedes the jump's F0.

## Structure
- Shared package risc_pkg: opcode localparams (OP_ADD … OP_HALT), state enum, and IMM_BIT index; both ALU tests and this block use it.
- One natural sub-module: risc_decode (combinational IR0 -> class flags: is_alu, is_mem, is_jump, sets_carry).
- FSM, PC and IR registers live in the top level.

## Test plan
- Reset: Reset_n pulsed low mid-EXM -> all strobes drop within the same cycle; state IDLE; PC=0.
- Immediate ADD: program {0x01,0x05} at 0, StartAddr=0 -> SRAMRead in F0 (addr 0) and F1 (addr 1); ALUSave+ZflagSave+CflagSave with Operand2=0x05 on cycle 4; next F0 addr 2.
- Memory AND: {0x10,0x80}, SRAM[0x80]=0x3C -> SRAMRead addr 0x80 in EX; ALUSave with Operand2=0x3C in EXM; CflagSave=0; 5-cycle instruction.
- Conditional jump: JZ 0x40 with Zflag=1 -> next F0 addr 0x40. Same instruction with Zflag=0 -> next F0 addr PC+2.
- Wrap: StartAddr=0xFF, NOP -> fetch addrs 0xFF then 0x00; next F0 addr 0x01.
- PUSH, POP, STORE, HALT sequence -> StackWrite, StackRead and SRAMWrite (addr IR1) each exactly one cycle; Halted=1 persists while Start toggles.
